// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Shares the 8-digit seven-segment display between three 32-bit sources:
// status word, memory-inspect word and a held snapshot of the last CPU store.
// A registered source FSM picks the word, a prescaler paces the digit scan,
// and the scanned word is latched once per frame so it never tears.
//
// Ports:
//   CLK100MHZ    in   board clock, rising edge
//   resetn       in   synchronous active-low reset
//   wr_evt       in   CPU store strobe (level-sampled)
//   wr_adr       in   [31:0] store address
//   wr_data      in   [31:0] store data
//   show         in   1 = memory view, 0 = status view
//   mem_data     in   [31:0] memory-inspect word
//   status_data  in   [31:0] status word
//   seg          out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an           out  [7:0] digit enables, active-low one-hot
//   src          out  [1:0] current source: 0 STATUS, 1 MEM, 2 HOLD
module seg_display_arbiter #(
    parameter int unsigned SCAN_DIV    = 262144,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic        CLK100MHZ,
    input  logic        resetn,
    input  logic        wr_evt,
    input  logic [31:0] wr_adr,
    input  logic [31:0] wr_data,
    input  logic        show,
    input  logic [31:0] mem_data,
    input  logic [31:0] status_data,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic [1:0]  src
);

    localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_STATUS = 2'd0;
    localparam logic [1:0] ST_MEM    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic [31:0]       hold_reg;
    logic [31:0]       hold_reg_next;

    logic [PRE_W-1:0]  pre;
    logic              tick;
    logic [2:0]        idx;
    logic [31:0]       frame;
    logic [31:0]       sel_word;
    logic [3:0]        nibble;

    // Only the word-address byte of the store address and the low half of
    // the store data are shown; the rest is intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{wr_adr[31:10], wr_adr[1:0], wr_data[31:16]};

    // Hex digit to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Source FSM next state; a store event always wins.
    // The counter is loaded with HOLD_CYCLES so src reads HOLD from the event
    // edge through HOLD_CYCLES edges later, leaving on the edge after it hits 0.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        hold_reg_next = hold_reg;
        if (wr_evt) begin
            state_next    = ST_HOLD;
            hold_reg_next = {8'hEE, wr_adr[9:2], wr_data[15:0]};
            hold_cnt_next = HOLD_W'(HOLD_CYCLES);
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state_next = show ? ST_MEM : ST_STATUS;
                    end else begin
                        hold_cnt_next = hold_cnt - HOLD_W'(1);
                    end
                end
                default: state_next = show ? ST_MEM : ST_STATUS;
            endcase
        end
    end

    // Source FSM registers
    always_ff @(posedge CLK100MHZ) begin
        if (!resetn) begin
            state    <= ST_STATUS;
            hold_cnt <= '0;
            hold_reg <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            hold_reg <= hold_reg_next;
        end
    end

    assign src = state;

    always_comb begin
        case (state)
            ST_HOLD: sel_word = hold_reg;
            ST_MEM:  sel_word = mem_data;
            default: sel_word = status_data;
        endcase
    end

    assign tick   = (pre == PRE_W'(SCAN_DIV - 1));
    assign nibble = frame[{idx, 2'b00} +: 4];

    // Prescaler and digit scanner; frame reloads only after digit 7
    always_ff @(posedge CLK100MHZ) begin
        if (!resetn) begin
            pre   <= '0;
            idx   <= '0;
            frame <= '0;
            an    <= 8'hFF;
            seg   <= 7'h7F;
        end else begin
            pre <= tick ? '0 : pre + PRE_W'(1);
            if (tick) begin
                an  <= ~(8'b1 << idx);
                seg <= hex7(nibble);
                idx <= idx + 3'd1;
                if (idx == 3'd7) begin
                    frame <= sel_word;
                end
            end
        end
    end

endmodule
